// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: widths, ALU opcodes, issue entry and buffer state.
package alu_pkg;
  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;

  typedef logic [2:0] aluop_t;
  localparam aluop_t ALUOP_AND = 3'b000;
  localparam aluop_t ALUOP_OR  = 3'b001;
  localparam aluop_t ALUOP_ADD = 3'b010;
  localparam aluop_t ALUOP_SUB = 3'b110;
  localparam aluop_t ALUOP_SLT = 3'b111;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic                      use_imm;
    logic [DATA_WIDTH-1:0]     a;
    logic [DATA_WIDTH-1:0]     b;
    aluop_t                    aluop;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } issue_entry_t;

  // Refresh a held entry's source operands from the writeback bus; register 0 never matches.
  function automatic issue_entry_t held_forward(issue_entry_t e, logic byp_valid,
                                                logic [REG_ADDR_WIDTH-1:0] byp_rd,
                                                logic [DATA_WIDTH-1:0] byp_data);
    issue_entry_t r;
    r = e;
    if (byp_valid && (byp_rd != '0)) begin
      if (e.rs1 == byp_rd) r.a = byp_data;
      if (!e.use_imm && (e.rs2 == byp_rd)) r.b = byp_data;
    end
    return r;
  endfunction
endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-side, bypass and ALU-side signals of the issue stage. Both sides use valid/ready:
// a transfer happens on a rising edge where valid and ready are both high; valid never waits on ready.
interface alu_issue_stage_if;
  import alu_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [REG_ADDR_WIDTH-1:0] in_rs1;
  logic [REG_ADDR_WIDTH-1:0] in_rs2;
  logic [DATA_WIDTH-1:0]     in_rs1_data;
  logic [DATA_WIDTH-1:0]     in_rs2_data;
  logic [DATA_WIDTH-1:0]     in_imm;
  logic                      in_use_imm;
  logic [2:0]                in_aluop;
  logic [REG_ADDR_WIDTH-1:0] in_rd;
  logic                      byp_valid;
  logic [REG_ADDR_WIDTH-1:0] byp_rd;
  logic [DATA_WIDTH-1:0]     byp_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH-1:0]     out_A;
  logic [DATA_WIDTH-1:0]     out_B;
  logic [2:0]                out_aluop;
  logic [REG_ADDR_WIDTH-1:0] out_rd;
  buf_state_e                dbg_state;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rs1_data, in_rs2_data, in_imm, in_use_imm,
           in_aluop, in_rd, byp_valid, byp_rd, byp_data, out_ready,
    input  in_ready, out_valid, out_A, out_B, out_aluop, out_rd, dbg_state
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rs1_data, in_rs2_data, in_imm, in_use_imm,
           in_aluop, in_rd, byp_valid, byp_rd, byp_data, out_ready,
    output in_ready, out_valid, out_A, out_B, out_aluop, out_rd, dbg_state
  );
endinterface

// File: rtl/alu_issue_scoreboard.sv
// Per-register busy table for the issue interlock; set wins over clear on the same index.
module alu_issue_scoreboard
  import alu_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      set_en,
  input  logic [REG_ADDR_WIDTH-1:0] set_idx,
  input  logic                      clr_en,
  input  logic [REG_ADDR_WIDTH-1:0] clr_idx,
  input  logic [REG_ADDR_WIDTH-1:0] query_a,
  input  logic [REG_ADDR_WIDTH-1:0] query_b,
  output logic                      busy_a,
  output logic                      busy_b
);
  logic [NUM_REGS-1:0] busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clr_en && (clr_idx != '0)) busy[clr_idx] <= 1'b0;
      if (set_en && (set_idx != '0)) busy[set_idx] <= 1'b1;
    end
  end

  // Register 0 is never set, so its query is always clear.
  assign busy_a = busy[query_a];
  assign busy_b = busy[query_b];
endmodule

// File: rtl/alu_issue_stage.sv
// Two-entry skid buffer in front of the ALU with capture and held operand forwarding.
// Define ALU_ISSUE_SCOREBOARD_EN to add the busy-table interlock on the head entry.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  alu_issue_stage_if.slave  io
);
  buf_state_e   state;
  issue_entry_t head, skid, cap, head_fwd, skid_fwd;
  logic         head_busy, in_fire, out_fire;

  always_comb begin
    cap         = '0;
    cap.rs1     = io.in_rs1;
    cap.rs2     = io.in_rs2;
    cap.use_imm = io.in_use_imm;
    cap.aluop   = io.in_aluop;
    cap.rd      = io.in_rd;
    cap.a       = (io.byp_valid && (io.byp_rd == io.in_rs1) && (io.in_rs1 != '0))
                  ? io.byp_data : io.in_rs1_data;
    if (io.in_use_imm)
      cap.b = io.in_imm;
    else if (io.byp_valid && (io.byp_rd == io.in_rs2) && (io.in_rs2 != '0))
      cap.b = io.byp_data;
    else
      cap.b = io.in_rs2_data;
  end

  assign head_fwd = held_forward(head, io.byp_valid, io.byp_rd, io.byp_data);
  assign skid_fwd = held_forward(skid, io.byp_valid, io.byp_rd, io.byp_data);

`ifdef ALU_ISSUE_SCOREBOARD_EN
  logic busy_rs1, busy_rs2;

  alu_issue_scoreboard u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (out_fire && (head.rd != '0)),
    .set_idx (head.rd),
    .clr_en  (io.byp_valid),
    .clr_idx (io.byp_rd),
    .query_a (head.rs1),
    .query_b (head.rs2),
    .busy_a  (busy_rs1),
    .busy_b  (busy_rs2)
  );

  assign head_busy = busy_rs1 || (!head.use_imm && busy_rs2);
`else
  assign head_busy = 1'b0;
`endif

  assign io.in_ready  = (state != BUF_FULL) && !rst;
  assign io.out_valid = (state != BUF_EMPTY) && !head_busy;
  assign io.out_A     = head.a;
  assign io.out_B     = head.b;
  assign io.out_aluop = head.aluop;
  assign io.out_rd    = head.rd;
  assign io.dbg_state = state;

  assign in_fire  = io.in_valid && io.in_ready;
  assign out_fire = io.out_valid && io.out_ready;

  // Held entries always take the forwarded value; a leaving head simply discards it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BUF_EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      head <= head_fwd;
      skid <= skid_fwd;
      case (state)
        BUF_EMPTY: begin
          if (in_fire) begin
            head  <= cap;
            state <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (in_fire && out_fire) begin
            head <= cap;
          end else if (in_fire) begin
            skid  <= cap;
            state <= BUF_FULL;
          end else if (out_fire) begin
            state <= BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (out_fire) begin
            head  <= skid_fwd;
            state <= BUF_ONE;
          end
        end
        default: state <= BUF_EMPTY;
      endcase
    end
  end
endmodule
